// File: rtl/wb_ram_pkg.sv
// Shared definitions for the Wishbone-to-OpenRAM responders: bus widths,
// responder FSM state encoding and the SRAM port idle values.
package wb_ram_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_SEL_W  = 4;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RD_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK     = 2'd2;

    localparam logic                 SRAM_CSB_IDLE   = 1'b1;
    localparam logic                 SRAM_WEB_IDLE   = 1'b1;
    localparam logic [WB_SEL_W-1:0]  SRAM_WMASK_IDLE = 4'b0000;
    localparam logic [WB_DATA_W-1:0] SRAM_DIN_IDLE   = 32'h0000_0000;

    // Byte-lane write mask: lanes only qualify on writes.
    function automatic logic [WB_SEL_W-1:0] wmask_of(input logic we, input logic [WB_SEL_W-1:0] sel);
        logic [WB_SEL_W-1:0] m;
        if (we) begin
            m = sel;
        end else begin
            m = SRAM_WMASK_IDLE;
        end
        return m;
    endfunction

endpackage

// File: rtl/wishbone_sram_responder.sv
// Wishbone classic slave driving one OpenRAM single-port SRAM macro: one SRAM
// access per bus cycle, registered single-cycle acknowledge.
module wishbone_sram_responder
    import wb_ram_pkg::*;
#(
    parameter int ADDR_WIDTH   = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_ni,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_we_i,
    input  logic [WB_SEL_W-1:0]   wbs_sel_i,
    input  logic [31:0]           wbs_adr_i,
    input  logic [WB_DATA_W-1:0]  wbs_dat_i,
    output logic                  wbs_ack_o,
    output logic [WB_DATA_W-1:0]  wbs_dat_o,
    output logic                  sram_clk0,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [WB_SEL_W-1:0]   sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [WB_DATA_W-1:0]  sram_din0,
    input  logic [WB_DATA_W-1:0]  sram_dout0
);

    localparam int                CNT_W    = $clog2(READ_LATENCY + 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    logic [1:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ack_q, ack_d;
    logic [WB_DATA_W-1:0] dat_q, dat_d;

    logic req_s;
    logic access_s;
    logic unused_adr_s;

    assign req_s = wbs_cyc_i & wbs_stb_i;
    // Reset gates the launch so the macro sees idle inputs the moment rst_n falls.
    assign access_s = wb_rst_ni & req_s & (state_q == ST_IDLE);
    assign unused_adr_s = ^{wbs_adr_i[31:ADDR_WIDTH+2], wbs_adr_i[1:0]};

    assign sram_clk0 = wb_clk_i;
    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;

    // SRAM port drive: live only in the IDLE cycle that launches an access.
    always_comb begin
        if (access_s) begin
            sram_csb0   = 1'b0;
            sram_web0   = ~wbs_we_i;
            sram_wmask0 = wmask_of(wbs_we_i, wbs_sel_i);
            sram_addr0  = wbs_adr_i[ADDR_WIDTH+1:2];
            sram_din0   = wbs_dat_i;
        end else begin
            sram_csb0   = SRAM_CSB_IDLE;
            sram_web0   = SRAM_WEB_IDLE;
            sram_wmask0 = SRAM_WMASK_IDLE;
            sram_addr0  = {ADDR_WIDTH{1'b0}};
            sram_din0   = SRAM_DIN_IDLE;
        end
    end

    // Next-state, latency counter, acknowledge and read-data capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        dat_d   = dat_q;
        case (state_q)
            ST_IDLE: begin
                dat_d = 32'h0000_0000;
                if (req_s) begin
                    if (wbs_we_i) begin
                        state_d = ST_ACK;
                        ack_d   = 1'b1;
                    end else begin
                        state_d = ST_RD_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                // Only a cycle abort cancels; a strobe drop lets the read finish.
                if (!wbs_cyc_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                    dat_d   = 32'h0000_0000;
                end else if (cnt_q == CNT_ZERO) begin
                    state_d = ST_ACK;
                    ack_d   = 1'b1;
                    dat_d   = sram_dout0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
                dat_d   = 32'h0000_0000;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
                dat_d   = 32'h0000_0000;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            ack_q   <= 1'b0;
            dat_q   <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
        end
    end

endmodule

// File: tb/tb_wishbone_sram_responder.sv
// Bench for wishbone_sram_responder: one instance at READ_LATENCY=1 and one at
// READ_LATENCY=3, each on its own behavioural SRAM, against a word-level model.
module tb_wishbone_sram_responder;

    localparam int AW    = 8;
    localparam int DEPTH = 256;
    localparam int RL_A  = 1;
    localparam int RL_B  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        stb, we, cyc_a, cyc_b;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;

    logic        ack_a, sclk_a, csb_a, web_a;
    logic [31:0] rdat_a, din_a, dout_a;
    logic [3:0]  wm_a;
    logic [7:0]  addr_a;
    logic        ack_b, sclk_b, csb_b, web_b;
    logic [31:0] rdat_b, din_b, dout_b;
    logic [3:0]  wm_b;
    logic [7:0]  addr_b;

    int checks;
    int errors;

    wishbone_sram_responder #(.ADDR_WIDTH(AW), .READ_LATENCY(RL_A)) dut_a (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_stb_i(stb), .wbs_cyc_i(cyc_a),
        .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
        .wbs_ack_o(ack_a), .wbs_dat_o(rdat_a), .sram_clk0(sclk_a), .sram_csb0(csb_a),
        .sram_web0(web_a), .sram_wmask0(wm_a), .sram_addr0(addr_a), .sram_din0(din_a),
        .sram_dout0(dout_a));

    wishbone_sram_responder #(.ADDR_WIDTH(AW), .READ_LATENCY(RL_B)) dut_b (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_stb_i(stb), .wbs_cyc_i(cyc_b),
        .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
        .wbs_ack_o(ack_b), .wbs_dat_o(rdat_b), .sram_clk0(sclk_b), .sram_csb0(csb_b),
        .sram_web0(web_b), .sram_wmask0(wm_b), .sram_addr0(addr_b), .sram_din0(din_b),
        .sram_dout0(dout_b));

    // Behavioural SRAM macros: capture on the clock edge, data after RL edges.
    logic [31:0] mem_a [DEPTH];
    logic [31:0] mem_b [DEPTH];
    logic [31:0] rd_a, p0_b, p1_b, p2_b;
    int wr_cnt_a, sel_cnt_a;

    always @(posedge sclk_a) begin
        if (!csb_a) begin
            sel_cnt_a <= sel_cnt_a + 1;
            if (!web_a) begin
                for (int i = 0; i < 4; i++) if (wm_a[i]) mem_a[addr_a][8*i +: 8] <= din_a[8*i +: 8];
                wr_cnt_a <= wr_cnt_a + 1;
            end else begin
                rd_a <= mem_a[addr_a];
            end
        end
    end
    assign dout_a = rd_a;

    always @(posedge sclk_b) begin
        if (!csb_b && !web_b) begin
            for (int i = 0; i < 4; i++) if (wm_b[i]) mem_b[addr_b][8*i +: 8] <= din_b[8*i +: 8];
        end
        if (!csb_b && web_b) p0_b <= mem_b[addr_b];
        p1_b <= p0_b;
        p2_b <= p1_b;
    end
    assign dout_b = p2_b;

    // Reference model: one word array per SRAM, updated per completed transfer.
    logic [31:0] ref_a [DEPTH];
    logic [31:0] ref_b [DEPTH];

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    task automatic ref_write(input int d, input int w, input logic [31:0] v, input logic [3:0] s);
        if (d == 0) ref_a[w] = merge(ref_a[w], v, s);
        else        ref_b[w] = merge(ref_b[w], v, s);
    endtask

    function automatic logic [31:0] ref_read(input int d, input int w);
        if (d == 0) return ref_a[w];
        else        return ref_b[w];
    endfunction

    function automatic int exp_lat(input int d, input bit w);
        if (w) return 1;
        return ((d == 0) ? RL_A : RL_B) + 1;
    endfunction

    // One Wishbone transfer on instance d; lat counts edges from request to ack.
    task automatic xfer(input int d, input bit w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] v, output logic [31:0] rd, output int lat);
        bit got;
        we = w; adr = a; sel = s; wdat = v; stb = 1'b1;
        if (d == 0) cyc_a = 1'b1; else cyc_b = 1'b1;
        got = 1'b0; lat = 0; rd = 32'h0;
        for (int n = 1; n <= 20 && !got; n++) begin
            @(posedge clk); #1;
            if ((d == 0) ? ack_a : ack_b) begin
                got = 1'b1; lat = n;
                rd = (d == 0) ? rdat_a : rdat_b;
            end
        end
        stb = 1'b0; cyc_a = 1'b0; cyc_b = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL ack_timeout dut%0d adr=%h: no ack within 20 cycles", d, a);
        end
        @(posedge clk); #1;
        checks++;
        if (((d == 0) ? {ack_a, rdat_a} : {ack_b, rdat_b}) !== 33'h0) begin
            errors++;
            $display("FAIL ack_pulse dut%0d: ack/dat after ack cycle = %b/%h, want 0/0", d,
                     (d == 0) ? ack_a : ack_b, (d == 0) ? rdat_a : rdat_b);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; stb = 1'b0; cyc_a = 1'b0; cyc_b = 1'b0; we = 1'b0;
        sel = 4'h0; adr = 32'h0; wdat = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ack_a, rdat_a, csb_a, web_a, wm_a, addr_a, din_a} !== {1'b0, 32'h0, 1'b1, 1'b1, 4'h0, 8'h0, 32'h0}) begin
            errors++;
            $display("FAIL reset_a: ack=%b dat=%h csb=%b web=%b wm=%h addr=%h din=%h, want idle",
                     ack_a, rdat_a, csb_a, web_a, wm_a, addr_a, din_a);
        end
        checks++;
        if ({ack_b, rdat_b, csb_b, web_b, wm_b} !== {1'b0, 32'h0, 1'b1, 1'b1, 4'h0}) begin
            errors++;
            $display("FAIL reset_b: ack=%b dat=%h csb=%b web=%b wm=%h, want idle", ack_b, rdat_b, csb_b, web_b, wm_b);
        end
        stb = 1'b1; cyc_a = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h10; wdat = 32'h1234_5678;
        #1;
        checks++;
        if ({csb_a, wm_a} !== {1'b1, 4'h0}) begin
            errors++;
            $display("FAIL reset_gates_sram: csb=%b wm=%h with request in reset, want 1/0", csb_a, wm_a);
        end
        stb = 1'b0; cyc_a = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fill;
        logic [31:0] rd, v;
        int lat;
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < DEPTH; w++) begin
                v = $urandom;
                xfer(d, 1'b1, w << 2, 4'hF, v, rd, lat);
                ref_write(d, w, v, 4'hF);
                checks++;
                if (lat != 1) begin
                    errors++;
                    $display("FAIL fill_lat dut%0d word %0d: latency %0d, want 1", d, w, lat);
                end
            end
        end
    endtask

    task automatic test_directed;
        logic [31:0] rd;
        int lat;
        we = 1'b1; adr = 32'h3000_0008; sel = 4'hF; wdat = 32'hDEAD_BEEF; stb = 1'b1; cyc_a = 1'b1;
        #1;
        checks++;
        if ({csb_a, web_a, addr_a, wm_a, din_a} !== {1'b0, 1'b0, 8'd2, 4'hF, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL write_pins: csb=%b web=%b addr=%h wm=%h din=%h, want 0/0/02/f/deadbeef",
                     csb_a, web_a, addr_a, wm_a, din_a);
        end
        xfer(0, 1'b1, 32'h3000_0008, 4'hF, 32'hDEAD_BEEF, rd, lat);
        ref_write(0, 2, 32'hDEAD_BEEF, 4'hF);
        checks++;
        if (lat != 1) begin
            errors++;
            $display("FAIL write_lat: got %0d, want 1", lat);
        end
        xfer(0, 1'b0, 32'h0000_0008, 4'hF, 32'h0, rd, lat);
        checks++;
        if (rd !== 32'hDEAD_BEEF || lat != 2) begin
            errors++;
            $display("FAIL read_back: dat=%h lat=%0d, want deadbeef lat 2", rd, lat);
        end
    endtask

    task automatic test_byte_write;
        logic [31:0] rd;
        int lat;
        xfer(0, 1'b1, 32'h14, 4'hF, 32'h1122_3344, rd, lat);
        ref_write(0, 5, 32'h1122_3344, 4'hF);
        xfer(0, 1'b1, 32'h14, 4'b0010, 32'h0000_AB00, rd, lat);
        ref_write(0, 5, 32'h0000_AB00, 4'b0010);
        xfer(0, 1'b0, 32'h14, 4'hF, 32'h0, rd, lat);
        checks++;
        if (rd !== 32'h1122_AB44) begin
            errors++;
            $display("FAIL byte_write: dat=%h, want 1122ab44", rd);
        end
        we = 1'b1; adr = 32'h14; sel = 4'h0; wdat = 32'hFFFF_FFFF; stb = 1'b1; cyc_a = 1'b1;
        #1;
        checks++;
        if ({csb_a, web_a, wm_a} !== {1'b0, 1'b0, 4'h0}) begin
            errors++;
            $display("FAIL zero_sel_pins: csb=%b web=%b wm=%h, want 0/0/0", csb_a, web_a, wm_a);
        end
        xfer(0, 1'b1, 32'h14, 4'h0, 32'hFFFF_FFFF, rd, lat);
        checks++;
        if (lat != 1) begin
            errors++;
            $display("FAIL zero_sel_lat: got %0d, want 1", lat);
        end
        xfer(0, 1'b0, 32'h14, 4'hF, 32'h0, rd, lat);
        checks++;
        if (rd !== ref_read(0, 5)) begin
            errors++;
            $display("FAIL zero_sel_data: dat=%h, want %h", rd, ref_read(0, 5));
        end
    endtask

    task automatic test_random;
        logic [31:0] rd, v, a;
        logic [3:0] s;
        int lat, d, w;
        bit wr;
        for (int n = 0; n < 150; n++) begin
            d  = $urandom_range(0, 1);
            wr = 1'($urandom_range(0, 1));
            w  = $urandom_range(0, DEPTH - 1);
            a  = ($urandom & 32'hFFFF_FC00) | (w << 2) | ($urandom & 32'h3);
            s  = 4'($urandom);
            v  = $urandom;
            xfer(d, wr, a, s, v, rd, lat);
            checks++;
            if (lat != exp_lat(d, wr)) begin
                errors++;
                $display("FAIL rand_lat dut%0d we=%0d: got %0d, want %0d", d, wr, lat, exp_lat(d, wr));
            end
            if (wr) begin
                ref_write(d, w, v, s);
            end else begin
                checks++;
                if (rd !== ref_read(d, w)) begin
                    errors++;
                    $display("FAIL rand_data dut%0d word %0d: got %h, want %h", d, w, rd, ref_read(d, w));
                end
            end
        end
    endtask

    task automatic test_latency3;
        logic [31:0] rd;
        int lat;
        xfer(1, 1'b0, 32'h1C, 4'hF, 32'h0, rd, lat);
        checks++;
        if (lat != 4 || rd !== ref_read(1, 7)) begin
            errors++;
            $display("FAIL latency3: lat=%0d dat=%h, want 4 and %h", lat, rd, ref_read(1, 7));
        end
    endtask

    task automatic test_abort;
        logic [31:0] rd;
        int lat;
        we = 1'b0; adr = 32'hC; sel = 4'hF; stb = 1'b1; cyc_a = 1'b1;
        @(posedge clk); #1;
        cyc_a = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            checks++;
            if (ack_a !== 1'b0 || rdat_a !== 32'h0) begin
                errors++;
                $display("FAIL abort_quiet cycle %0d: ack=%b dat=%h, want 0/0", n, ack_a, rdat_a);
            end
            if (n == 0) begin
                we = 1'b1; wdat = 32'h0BAD_F00D; cyc_a = 1'b1;
                #1;
                checks++;
                if (csb_a !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_idle: csb=%b after abort, want 0 (new access launched)", csb_a);
                end
                cyc_a = 1'b0; stb = 1'b0;
            end
        end
        xfer(0, 1'b1, 32'hC, 4'hF, 32'h0BAD_F00D, rd, lat);
        ref_write(0, 3, 32'h0BAD_F00D, 4'hF);
        checks++;
        if (lat != 1) begin
            errors++;
            $display("FAIL abort_next_write: lat=%0d, want 1", lat);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] vals [3];
        logic [31:0] rd;
        int acks[$];
        int w0, s0, k, lat;
        bit ok;
        for (int i = 0; i < 3; i++) vals[i] = $urandom;
        w0 = wr_cnt_a; s0 = sel_cnt_a; k = 0;
        we = 1'b1; sel = 4'hF; adr = 32'd40; wdat = vals[0]; stb = 1'b1; cyc_a = 1'b1;
        for (int c = 1; c <= 12 && k < 3; c++) begin
            @(posedge clk); #1;
            if (ack_a) begin
                acks.push_back(c);
                k++;
                if (k < 3) begin
                    adr = 32'd40 + 32'(4 * k);
                    wdat = vals[k];
                end
            end
        end
        stb = 1'b0; cyc_a = 1'b0;
        @(posedge clk); #1;
        ok = (acks.size() == 3);
        for (int i = 0; i < acks.size() && i < 3; i++) if (acks[i] != 2 * i + 1) ok = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_ack_spacing: %0d acks, want 3 on cycles 1,3,5", acks.size());
        end
        checks++;
        if (wr_cnt_a - w0 != 3 || sel_cnt_a - s0 != 3) begin
            errors++;
            $display("FAIL b2b_sram_accesses: writes=%0d selects=%0d, want 3/3", wr_cnt_a - w0, sel_cnt_a - s0);
        end
        for (int i = 0; i < 3; i++) begin
            ref_write(0, 10 + i, vals[i], 4'hF);
            xfer(0, 1'b0, 32'(40 + 4 * i), 4'hF, 32'h0, rd, lat);
            checks++;
            if (rd !== ref_read(0, 10 + i)) begin
                errors++;
                $display("FAIL b2b_data word %0d: got %h, want %h", 10 + i, rd, ref_read(0, 10 + i));
            end
        end
    endtask

    task automatic test_reset_mid_read;
        logic [31:0] rd;
        int lat;
        we = 1'b0; adr = 32'd80; sel = 4'hF; stb = 1'b1; cyc_b = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ack_b, rdat_b, csb_b} !== {1'b0, 32'h0, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid_read: ack=%b dat=%h csb=%b, want 0/0/1", ack_b, rdat_b, csb_b);
        end
        @(posedge clk); #1;
        checks++;
        if ({ack_b, rdat_b, csb_b} !== {1'b0, 32'h0, 1'b1}) begin
            errors++;
            $display("FAIL reset_hold: ack=%b dat=%h csb=%b, want 0/0/1", ack_b, rdat_b, csb_b);
        end
        stb = 1'b0; cyc_b = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(1, 1'b0, 32'd80, 4'hF, 32'h0, rd, lat);
        checks++;
        if (rd !== ref_read(1, 20) || lat != 4) begin
            errors++;
            $display("FAIL read_after_reset: dat=%h lat=%0d, want %h lat 4", rd, lat, ref_read(1, 20));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_fill();
        test_directed();
        test_byte_write();
        test_latency3();
        test_abort();
        test_back_to_back();
        test_random();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wishbone_sram_responder.md
# wishbone_sram_responder

Wishbone classic slave that sits below the RAM mux on one downstream port and drives a single OpenRAM single-port SRAM macro (active-low chip select and write enable, byte write mask, registered-address read). Converts each Wishbone cycle into exactly one SRAM access and returns a registered single-cycle acknowledge. One instance serves each SRAM on the test chip.

## Interface
Parameters:
- ADDR_WIDTH, 8, SRAM word-address width; word address = wbs_adr_i[ADDR_WIDTH+1:2].
- READ_LATENCY, 1, cycles from SRAM capture edge until sram_dout0 is valid; legal 1..3.

Ports (one clock; reset is asynchronous and active-low):
- wb_clk_i  in  1  clock; also drives sram_clk0.
- wb_rst_ni  in  1  asynchronous active-low reset.
- wbs_stb_i  in  1  strobe (already qualified by the mux decode).
- wbs_cyc_i  in  1  bus cycle.
- wbs_we_i  in  1  1 = write.
- wbs_sel_i  in  4  byte lanes.
- wbs_adr_i  in  32  byte address; bits [1:0] and above ADDR_WIDTH+1 ignored.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  registered acknowledge, one-cycle pulse.
- wbs_dat_o  out  32  read data, valid only while ack of a read.
- sram_clk0  out  1  = wb_clk_i.
- sram_csb0  out  1  active-low chip select.
- sram_web0  out  1  active-low write enable.
- sram_wmask0  out  4  byte write mask.
- sram_addr0  out  ADDR_WIDTH  word address.
- sram_din0  out  32  write data.
- sram_dout0  in  32  read data.

## Operation
- req = wbs_cyc_i & wbs_stb_i.
- States: IDLE, RD_WAIT, ACK.
- IDLE, req=0: sram_csb0=1, sram_web0=1, wmask=0, addr/din=0. Stay.
- IDLE, req=1: combinationally sram_csb0=0, sram_web0=~wbs_we_i, sram_wmask0 = we ? sel : 0, addr, din=dat_i; the macro captures at the same edge (E0).
  - write: next state ACK, ack_o<=1 at E0.
  - read: next state RD_WAIT, latency counter <= READ_LATENCY-1.
- RD_WAIT: SRAM inputs idle (csb=1). Counter decrements each edge; at the edge where counter==0, wbs_dat_o<=sram_dout0, ack_o<=1, state ACK.
- ACK: ack_o high this cycle; next edge ack_o<=0, wbs_dat_o<=0, state IDLE. A request present in that IDLE cycle starts a new access (no request is accepted while in ACK).
- Abort: cyc_i=0 in RD_WAIT -> IDLE at next edge, no ack, dat_o stays 0. stb_i drop with cyc_i high in RD_WAIT is ignored (access completes).
- Zero sel on write: SRAM still selected with wmask=0 (no bytes change); ack issued normally.
- Reset (any state, asynchronous): state IDLE, counter 0, wbs_ack_o=0, wbs_dat_o=0; SRAM outputs combinationally return to idle values (csb=1, web=1, wmask=0, addr=0, din=0).

## Timing
- Write: request sampled at E0, ack high in cycle E0..E1; 1-cycle latency.
- Read: ack high in cycle after edge E(READ_LATENCY); READ_LATENCY=1 -> ack 2 cycles after request.
- ack_o never high two consecutive cycles; maximum throughput one write per 2 cycles, one read per READ_LATENCY+2 cycles.
- wbs_dat_o nonzero only during a read ack cycle (so mux OR-combine is safe).

## Structure
- Shared package wb_ram_pkg: state encoding (IDLE/RD_WAIT/ACK), WB_DATA_W=32, WB_SEL_W=4, SRAM idle constants.
- Single module; no sub-module needed. Latency counter width $clog2(READ_LATENCY+1).

## Test plan
- Reset mid-read (wb_rst_ni low in RD_WAIT) -> ack_o=0, dat_o=0, csb=1 immediately; after release, next read works.
- Write adr 0x3000_0008, dat 0xDEADBEEF, sel 4'hF -> csb=0, web=0, addr=2, wmask=F at E0; ack one cycle later; then read adr 0x08 -> dat_o=0xDEADBEEF with ack 2 cycles after request (READ_LATENCY=1).
- Byte write sel 4'b0010, dat 0x0000_AB00 to word holding 0x11223344 -> readback 0x1122AB44.
- READ_LATENCY=3 build: read -> ack exactly 4 cycles after request, single pulse.
- Abort: cyc_i dropped in RD_WAIT -> no ack, FSM in IDLE next cycle, following write acked in 1 cycle.
- Back-to-back: stb held high across 3 writes -> acks on alternate cycles, 3 SRAM selects, no duplicate writes.
